// File: rtl/e906_bht_sram_ctrl.sv
// e906_bht_sram_ctrl
// Sequencer/arbiter in front of one BHT single-port SRAM macro. Shares the
// array between IFU predict reads and BJU update writes (one-entry write
// buffer) and walks the whole array with INIT_VAL after reset or invalidate.
// Every SRAM pin is registered, so the macro performs the operation at the
// edge after the one that sets the pins. pred_gnt is registered alongside the
// pins (high in the cycle the read is on the pins); pred_rvld follows it by
// one cycle with SRAM Q passed straight through.
//
// Optional feature: define E906_BHT_RD_WR_BYPASS_EN to merge a still-buffered
// write into read data when the read index matches the buffered index.
//
// state | meaning
// INIT  | init walk, one INIT_VAL word per cycle, requests blocked
// RUN   | arbitrate predict reads against buffered update writes
module e906_bht_sram_ctrl #(
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = 16'h5555
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  bht_inv_req,
    output logic                  bht_init_busy,
    input  logic                  pred_req,
    input  logic [ADDR_WIDTH-1:0] pred_idx,
    output logic                  pred_gnt,
    output logic                  pred_rvld,
    output logic [DATA_WIDTH-1:0] pred_rdata,
    input  logic                  upd_vld,
    input  logic [ADDR_WIDTH-1:0] upd_idx,
    input  logic [DATA_WIDTH-1:0] upd_wdata,
    input  logic [DATA_WIDTH-1:0] upd_mask,
    output logic                  upd_rdy,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam logic [0:0]            ST_INIT  = 1'b0;
    localparam logic [0:0]            ST_RUN   = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic                  r_busy;
    logic                  r_buf_full;
    logic [ADDR_WIDTH-1:0] r_buf_idx;
    logic [DATA_WIDTH-1:0] r_buf_data;
    logic [DATA_WIDTH-1:0] r_buf_mask;
    logic [ADDR_WIDTH-1:0] r_sram_a;
    logic                  r_sram_cen;
    logic                  r_sram_gwen;
    logic [DATA_WIDTH-1:0] r_sram_wen;
    logic [DATA_WIDTH-1:0] r_sram_d;
    logic                  r_pred_gnt;
    logic                  r_pred_rvld;

    logic w_init_wr;
    logic w_run;
    logic w_drain;
    logic w_read;
    logic w_upd_rdy;
    logic w_upd_acc;

    // Arbitration: a new update arriving while the buffer is full forces the
    // drain ahead of reads, otherwise reads win and the buffer drains when idle.
    // The cycle after the walk ends (busy still high) is left idle.
    always_comb begin
        w_init_wr = (r_state == ST_INIT) && !bht_inv_req;
        w_run     = (r_state == ST_RUN) && !r_busy && !bht_inv_req;
        w_drain   = w_run && r_buf_full && (upd_vld || !pred_req);
        w_read    = w_run && pred_req && !(r_buf_full && upd_vld);
        w_upd_rdy = w_run && (!r_buf_full || w_drain);
        w_upd_acc = upd_vld && w_upd_rdy;
    end

    // State, init walk counter and busy flag; invalidate always restarts at 0.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_busy     <= 1'b1;
        end else begin
            r_busy <= bht_inv_req || (r_state == ST_INIT);
            if (bht_inv_req) begin
                r_state    <= ST_INIT;
                r_init_cnt <= '0;
            end else if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
                if (r_init_cnt == LAST_IDX) begin
                    r_state <= ST_RUN;
                end
            end
        end
    end

    // One-entry update buffer; load and drain may coincide (new entry wins).
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_buf_full <= 1'b0;
            r_buf_idx  <= '0;
            r_buf_data <= '0;
            r_buf_mask <= '0;
        end else if (bht_inv_req) begin
            r_buf_full <= 1'b0;
        end else if (w_upd_acc) begin
            r_buf_full <= 1'b1;
            r_buf_idx  <= upd_idx;
            r_buf_data <= upd_wdata;
            r_buf_mask <= upd_mask;
        end else if (w_drain) begin
            r_buf_full <= 1'b0;
        end
    end

    // Registered SRAM pins plus the read grant/valid pipeline.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_sram_a    <= '0;
            r_sram_cen  <= 1'b1;
            r_sram_gwen <= 1'b1;
            r_sram_wen  <= '1;
            r_sram_d    <= '0;
            r_pred_gnt  <= 1'b0;
            r_pred_rvld <= 1'b0;
        end else begin
            r_pred_gnt  <= w_read;
            r_pred_rvld <= r_pred_gnt;
            r_sram_cen  <= 1'b1;
            r_sram_gwen <= 1'b1;
            r_sram_wen  <= '1;
            if (w_init_wr) begin
                r_sram_cen  <= 1'b0;
                r_sram_gwen <= 1'b0;
                r_sram_wen  <= '0;
                r_sram_a    <= r_init_cnt;
                r_sram_d    <= INIT_VAL;
            end else if (w_drain) begin
                r_sram_cen  <= 1'b0;
                r_sram_gwen <= 1'b0;
                r_sram_wen  <= ~r_buf_mask;
                r_sram_a    <= r_buf_idx;
                r_sram_d    <= r_buf_data;
            end else if (w_read) begin
                r_sram_cen  <= 1'b0;
                r_sram_a    <= pred_idx;
            end
        end
    end

`ifdef E906_BHT_RD_WR_BYPASS_EN
    logic                  r_byp_hit;
    logic [DATA_WIDTH-1:0] r_byp_data;
    logic [DATA_WIDTH-1:0] r_byp_mask;

    // Snapshot the buffer while the read is on the pins: anything buffered
    // then cannot have reached the array before the read executes.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_byp_hit  <= 1'b0;
            r_byp_data <= '0;
            r_byp_mask <= '0;
        end else if (r_pred_gnt) begin
            r_byp_hit  <= r_buf_full && (r_buf_idx == r_sram_a);
            r_byp_data <= r_buf_data;
            r_byp_mask <= r_buf_mask;
        end
    end

    // Read data: raw Q or Q merged with the matching buffered write.
    always_comb begin
        pred_rdata = '0;
        if (r_pred_rvld) begin
            pred_rdata = r_byp_hit ? ((r_byp_data & r_byp_mask) | (sram_q & ~r_byp_mask))
                                   : sram_q;
        end
    end
`else
    // Read data: raw Q; a still-buffered write to the same index is not seen.
    always_comb begin
        pred_rdata = r_pred_rvld ? sram_q : '0;
    end
`endif

    assign bht_init_busy = r_busy;
    assign pred_gnt      = r_pred_gnt;
    assign pred_rvld     = r_pred_rvld;
    assign upd_rdy       = w_upd_rdy;
    assign sram_a        = r_sram_a;
    assign sram_cen      = r_sram_cen;
    assign sram_gwen     = r_sram_gwen;
    assign sram_wen      = r_sram_wen;
    assign sram_d        = r_sram_d;

endmodule
